uart_tx_fifo: RTL
=================

# uart_tx_fifo

Buffered UART transmitter: the transmit-side counterpart of the UART receive path with sync FIFO. Host logic pushes bytes into an internal synchronous FIFO; a framing FSM pops them and serializes each as 8N1 (start, LSB-first data, stop) on `tx` at `BAUD_RATE`. It sits between the DDR/AXI read-back path and the board UART pin, so stored data can be echoed back to the host PC.

## Interface
- `DATA_WIDTH`, 8: bits per character.
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in bit/s.
- `DEPTH`, 1024: FIFO entries; power of two, at least 2.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `w_en` input 1: push `data_in` when the FIFO is not full.
- `data_in` input DATA_WIDTH: byte to transmit.
- `full` output 1: FIFO holds DEPTH entries.
- `empty` output 1: FIFO holds 0 entries.
- `overflow` output 1: one-cycle pulse when a write is dropped.
- `tx` output 1: serial line, idle high.
- `busy` output 1: high from the start bit through the last stop cycle.
- `done` output 1: one-cycle pulse in the final cycle of each stop bit.

## Operation
- `CLKS_PER_BIT` = CLK_FREQ / BAUD_RATE, with integer truncation. The default is 868.
- Baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and resets at every bit boundary.
- FSM states:
  - IDLE: `tx`=1. If `!empty`, pop into the shift register and go to START.
  - START: `tx`=0 for one bit time, then go to DATA.
  - DATA: `tx`=shift[0] and shift right each bit. After DATA_WIDTH bits, go to PARITY if enabled, otherwise STOP.
  - PARITY (macro only): one bit time, then go to STOP.
  - STOP: `tx`=1 for one bit time and pulse `done` in its last cycle. If `!empty` in that cycle, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- FIFO rules:
  - Pointers are $clog2(DEPTH)+1 bits. Full and empty come from the MSB compare and wrap naturally.
  - A write while `full` is dropped and pulses `overflow`. This holds even if a pop happens in the same cycle.
  - A simultaneous write and pop while neither full nor empty leaves the count unchanged.
  - Pops only occur when `!empty`, so the FSM never underflows.
- Reset values: `tx`=1, `busy`=0, `done`=0, `overflow`=0, `empty`=1, `full`=0, FSM=IDLE, pointers=0.
- Reset asserted mid-frame aborts the frame. `tx` returns to 1 asynchronously and FIFO contents are discarded.

## Timing
- A write in cycle N makes `empty`=0 at N+1.
- The FSM pops at N+1, and `tx` falls and `busy` rises at N+2. Latency from write to start bit is 2 cycles.
- Each bit lasts exactly CLKS_PER_BIT cycles.
- A frame lasts (2+DATA_WIDTH)·CLKS_PER_BIT cycles, or one more bit time with parity. The default is 8680 cycles, 86.8 µs.
- Back-to-back frames: the next start bit begins in the cycle after the previous stop bit's last cycle.
- `busy` deasserts only when entering IDLE.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: an even-parity bit (XOR of the data bits) is inserted between the data bits and the stop bit. The frame becomes 11 bit times.
- Undefined: the PARITY state and its logic are absent, and the frame is 8N1.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `tx_state_t` (IDLE, START, DATA, PARITY, STOP).
  - Function `clks_per_bit(clk_freq, baud)`.
  - Default frequency, baud and width constants, also used by the RX side.
- One sub-module, `uart_tx_fifo_buf`: the synchronous FIFO (storage, pointers, full/empty).
- The FSM and baud counter live in `uart_tx_fifo`.

## Test plan
- Write 0xAA once → `tx` falls 2 cycles later. Sampling at mid-bit gives 0,0,1,0,1,0,1,0,1,1. `done` pulses at cycle 8680 of the frame.
- Write 0x55, 0x35, 0x09 on consecutive cycles → three contiguous frames with no idle gap. `busy` stays high for 26040 cycles and `done` pulses three times.
- Fill with DEPTH writes while blocked by a long frame, then perform one more write → `full`=1, a single `overflow` pulse, and exactly DEPTH+1 frames decoded, since the first byte was popped before the FIFO filled.
- Assert `rst_n` low during bit 4 of 0xFF → `tx`=1 immediately and `empty`=1. After release, `tx` stays idle and no `done` pulse occurs.
- With `UART_TX_PARITY_EN`, send 0x07 → parity bit 1, an 11-bit frame, and `done` at cycle 9548.
- Simultaneous write and pop at count 1 → count stays 1, and the written byte is transmitted next in order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the TX and RX paths:
// default line settings, the transmit FSM state type and the bit-time helper.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;
  localparam int unsigned UART_CLK_FREQ   = 100_000_000;
  localparam int unsigned UART_BAUD_RATE  = 115_200;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  // Clock cycles per serial bit, truncated.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_buf.sv
// Synchronous FIFO for the UART transmitter. The read data is presented
// combinationally from the read pointer, so a pop and its data share a cycle.
module uart_tx_fifo_buf #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_rd,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_overflow
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic                  r_overflow;
  logic                  w_push;
  logic                  w_pop;

  // The extra pointer MSB tells a full ring from an empty one.
  assign o_full     = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                      (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_push     = i_wr && !o_full;
  assign w_pop      = i_rd && !o_empty;
  assign o_rdata    = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign o_overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_overflow <= i_wr && o_full;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO feeding an 8N1 framing FSM.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH = uart_pkg::UART_DATA_WIDTH,
  parameter int unsigned CLK_FREQ   = uart_pkg::UART_CLK_FREQ,
  parameter int unsigned BAUD_RATE  = uart_pkg::UART_BAUD_RATE,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  import uart_pkg::*;

  localparam int unsigned CPB    = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned BAUD_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CPB - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  tx_state_t             r_state;
  tx_state_t             w_state_next;
  logic [BAUD_W-1:0]     r_baud;
  logic [BIT_W-1:0]      r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_pop;
  logic                  w_bit_end;
`ifdef UART_TX_PARITY_EN
  logic                  r_parity;
`endif

  uart_tx_fifo_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr       (w_en),
    .i_wdata    (data_in),
    .i_rd       (w_pop),
    .o_rdata    (w_rdata),
    .o_full     (full),
    .o_empty    (empty),
    .o_overflow (overflow)
  );

  assign w_bit_end = (r_baud == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      if (r_state == IDLE || w_bit_end) r_baud <= '0;
      else                              r_baud <= r_baud + BAUD_W'(1);

      if (w_pop) begin
        r_shift <= w_rdata;
        r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
        r_parity <= ^w_rdata;
`endif
      end else if (r_state == DATA && w_bit_end) begin
        r_shift <= r_shift >> 1;
        r_bit   <= r_bit + BIT_W'(1);
      end
    end
  end

  // Outputs decode from registered state, so reset drives tx high at once.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    tx           = 1'b1;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (!empty) begin
          w_pop        = 1'b1;
          w_state_next = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (w_bit_end) w_state_next = DATA;
      end
      DATA: begin
        tx = r_shift[0];
        if (w_bit_end && r_bit == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = PARITY;
`else
          w_state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx = r_parity;
        if (w_bit_end) w_state_next = STOP;
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          done = 1'b1;
          if (!empty) begin
            w_pop        = 1'b1;
            w_state_next = START;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule
